// File: rtl/wbslave_regs_pkg.sv
// Shared definitions for the wbslave_regs Wishbone classic slave: bus widths and FSM encodings.
// Bus widths correspond to address_width/data_width/select_width of the master side.
package wbslave_regs_pkg;

  localparam int WB_AW = 8;
  localparam int WB_DW = 8;
  localparam int WB_SW = 1;

  typedef enum logic [1:0] {
    WB_S_IDLE = 2'd0,
    WB_S_WAIT = 2'd1,
    WB_S_ACK  = 2'd2,
    WB_S_ERR  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wbslave_regs_if.sv
// Wishbone classic bus bundle between wbmaster and wbslave_regs, including the interrupt return.
interface wbslave_regs_if
  import wbslave_regs_pkg::*;
#(
  parameter int AW = WB_AW,
  parameter int DW = WB_DW,
  parameter int SW = WB_SW
);
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          we;
  logic [SW-1:0] sel;
  logic          stb;
  logic          cyc;
  logic          ack;
  logic          err;
  logic          intr;

  modport master (
    output adr, dat_w, we, sel, stb, cyc,
    input  dat_r, ack, err, intr
  );

  modport slave (
    input  adr, dat_w, we, sel, stb, cyc,
    output dat_r, ack, err, intr
  );
endinterface

// File: rtl/wbslave_regs_regfile.sv
// DEPTH x DW register storage for wbslave_regs: synchronous write, combinational read,
// asynchronous active-low clear; bit0 of the top entry drives the interrupt.
module wbslave_regfile #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          intr_bit
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[idx] <= wr_data;
    end
  end

  assign rd_data  = mem[idx];
  assign intr_bit = mem[DEPTH-1][0];

endmodule

// File: rtl/wbslave_regs.sv
// Wishbone classic register slave with programmable wait states and an interrupt line.
// Optional: define WBSLAVE_ADDR_CHECK_EN to terminate addresses >= DEPTH with ERR.
//
// state | meaning
// IDLE  | waiting for CYC&STB; request fields latched on the sampling edge
// WAIT  | counting down wait states; CYC drop aborts without a write
// ACK   | ack high for one cycle; read data valid, write lands on exit edge
// ERR   | err high for one cycle; no register change
module wbslave_regs
  import wbslave_regs_pkg::*;
#(
  parameter int AW          = WB_AW,
  parameter int DW          = WB_DW,
  parameter int SW          = WB_SW,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input logic           clk_i,
  input logic           rst_i,
  wbslave_regs_if.slave wb
);

  localparam int IW = $clog2(DEPTH);

  wb_state_e     state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [IW-1:0] idx_q, idx_nxt;
  logic [DW-1:0] dat_q, dat_nxt;
  logic          we_q, we_nxt;
  logic          sel0_q, sel0_nxt;
  logic          ack_q;
  logic          req;
  logic          adr_bad;
  logic          wr_en;
  logic [DW-1:0] rd_data;
  logic          intr_bit;

  assign req = wb.cyc && wb.stb;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx_q;
    dat_nxt   = dat_q;
    we_nxt    = we_q;
    sel0_nxt  = sel0_q;
    case (state)
      WB_S_IDLE: begin
        if (req) begin
          idx_nxt  = wb.adr[IW-1:0];
          dat_nxt  = wb.dat_w;
          we_nxt   = wb.we;
          sel0_nxt = wb.sel[0];
          if (adr_bad) begin
            state_nxt = WB_S_ERR;
          end else if (WAIT_STATES == 0) begin
            state_nxt = WB_S_ACK;
          end else begin
            cnt_nxt   = 4'(WAIT_STATES - 1);
            state_nxt = WB_S_WAIT;
          end
        end
      end
      WB_S_WAIT: begin
        if (!wb.cyc) begin
          state_nxt = WB_S_IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = WB_S_ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WB_S_ACK:  state_nxt = WB_S_IDLE;
      WB_S_ERR:  state_nxt = WB_S_IDLE;
      default:   state_nxt = WB_S_IDLE;
    endcase
  end

  // ack is registered from the next-state decode so it is high exactly while in ACK
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= WB_S_IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      dat_q  <= '0;
      we_q   <= 1'b0;
      sel0_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx_q  <= idx_nxt;
      dat_q  <= dat_nxt;
      we_q   <= we_nxt;
      sel0_q <= sel0_nxt;
      ack_q  <= (state_nxt == WB_S_ACK);
    end
  end

`ifdef WBSLAVE_ADDR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= (state_nxt == WB_S_ERR);
  end

  assign adr_bad = ({1'b0, wb.adr} >= (AW+1)'(DEPTH));
  assign wb.err  = err_q;
`else
  assign adr_bad = 1'b0;
  assign wb.err  = 1'b0;

  // upper address bits only matter for the range check
  if (IW < AW) begin : g_alias
    logic unused_adr;
    assign unused_adr = ^wb.adr[AW-1:IW];
  end
`endif

  assign wr_en = ack_q && we_q && sel0_q;

  wbslave_regfile #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_regfile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en    (wr_en),
    .idx      (idx_q),
    .wr_data  (dat_q),
    .rd_data  (rd_data),
    .intr_bit (intr_bit)
  );

  assign wb.ack   = ack_q;
  assign wb.dat_r = (ack_q && !we_q) ? rd_data : '0;
  assign wb.intr  = intr_bit;

endmodule

// File: tb/tb_wbslave_regs.sv
// Self-checking bench for wbslave_regs (DEPTH=16, WAIT_STATES=1); works with or without
// WBSLAVE_ADDR_CHECK_EN defined.
module tb_wbslave_regs;
  import wbslave_regs_pkg::*;

  localparam int DEPTH = 16;
  localparam int WS    = 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  wbslave_regs_if #(.AW(8), .DW(8), .SW(1)) wb();

  wbslave_regs #(
    .AW(8), .DW(8), .SW(1), .DEPTH(DEPTH), .WAIT_STATES(WS)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wb    (wb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [DEPTH];

  typedef struct {
    string      name;
    logic [7:0] adr;
    logic [7:0] dat;
    logic       we;
    logic       sel;
    logic       exp_ack;
    logic       exp_err;
    logic [7:0] exp_rd;
    logic       exp_intr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic legal(input logic [7:0] adr);
`ifdef WBSLAVE_ADDR_CHECK_EN
    return adr < 8'(DEPTH);
`else
    return (adr == adr);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
  endtask

  task automatic drive_idle();
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.sel = 1'b0;
    wb.adr = 8'h00; wb.dat_w = 8'h00;
  endtask

  // One bus transfer; returns the termination, read data and edges counted from the sampling edge.
  task automatic xfer(input logic [7:0] adr, input logic [7:0] dat, input logic we, input logic sel,
                      output logic got_ack, output logic got_err, output logic [7:0] rd,
                      output int lat);
    got_ack = 1'b0; got_err = 1'b0; rd = 8'h00; lat = 0;
    @(negedge clk_i);
    wb.adr = adr; wb.dat_w = dat; wb.we = we; wb.sel = sel;
    wb.cyc = 1'b1; wb.stb = 1'b1;
    while (!(got_ack || got_err) && lat < 16) begin
      @(posedge clk_i); #1;
      lat++;
      got_ack = wb.ack; got_err = wb.err; rd = wb.dat_r;
    end
    chk("ack_err_exclusive", 32'(wb.ack & wb.err), 32'd0);
    drive_idle();
    @(posedge clk_i); #1;
    chk("term_one_cycle", 32'({wb.ack, wb.err}), 32'd0);
    chk("dat_zero_no_ack", 32'(wb.dat_r), 32'd0);
  endtask

  task automatic do_model(input string tag, input logic [7:0] adr, input logic [7:0] dat,
                          input logic we, input logic sel);
    logic a, e, lg;
    logic [7:0] rd;
    logic [3:0] ix;
    int lat;
    lg = legal(adr);
    ix = adr[3:0];
    xfer(adr, dat, we, sel, a, e, rd, lat);
    chk({tag, "_ack"}, 32'(a), 32'(lg));
    chk({tag, "_err"}, 32'(e), 32'(!lg));
    chk({tag, "_lat"}, 32'(lat), lg ? 32'(WS + 1) : 32'd1);
    chk({tag, "_rdata"}, 32'(rd), (lg && !we) ? 32'(model[ix]) : 32'd0);
    if (lg && we && sel) model[ix] = dat;
    chk({tag, "_intr"}, 32'(wb.intr), 32'(model[DEPTH-1][0]));
  endtask

  initial begin
    logic a, e, seen;
    logic [7:0] rd;
    int lat, nack, prev;

    vecs[0] = '{"wr05",     8'h05, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{"rd05",     8'h05, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0};
    vecs[2] = '{"intr_set", 8'h0F, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{"rd0f",     8'h0F, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1};
    vecs[4] = '{"intr_clr", 8'h0F, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
`ifdef WBSLAVE_ADDR_CHECK_EN
    vecs[5] = '{"wr20",     8'h20, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[6] = '{"rd00",     8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
`else
    vecs[5] = '{"wr20",     8'h20, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{"rd00",     8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 1'b0};
`endif
    vecs[7] = '{"wr03_sel0",8'h03, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[8] = '{"rd03",     8'h03, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

    drive_idle();
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ack",  32'(wb.ack),   32'd0);
    chk("reset_err",  32'(wb.err),   32'd0);
    chk("reset_dat",  32'(wb.dat_r), 32'd0);
    chk("reset_intr", 32'(wb.intr),  32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 9; i++) begin
      xfer(vecs[i].adr, vecs[i].dat, vecs[i].we, vecs[i].sel, a, e, rd, lat);
      chk({vecs[i].name, "_ack"},   32'(a),   32'(vecs[i].exp_ack));
      chk({vecs[i].name, "_err"},   32'(e),   32'(vecs[i].exp_err));
      chk({vecs[i].name, "_lat"},   32'(lat), vecs[i].exp_ack ? 32'(WS + 1) : 32'd1);
      chk({vecs[i].name, "_rdata"}, 32'(rd),  32'(vecs[i].exp_rd));
      chk({vecs[i].name, "_intr"},  32'(wb.intr), 32'(vecs[i].exp_intr));
      if (vecs[i].exp_ack && vecs[i].we && vecs[i].sel) model[vecs[i].adr[3:0]] = vecs[i].dat;
    end

    // abort: drop CYC while waiting
    @(negedge clk_i);
    wb.adr = 8'h02; wb.dat_w = 8'h55; wb.we = 1'b1; wb.sel = 1'b1; wb.cyc = 1'b1; wb.stb = 1'b1;
    @(posedge clk_i); #1;
    drive_idle();
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
      seen = seen | wb.ack | wb.err;
    end
    chk("abort_no_term", 32'(seen), 32'd0);
    do_model("abort_rd02", 8'h02, 8'h00, 1'b0, 1'b1);

    // STB/ADR/DAT/WE changes during WAIT are ignored
    @(negedge clk_i);
    wb.adr = 8'h06; wb.dat_w = 8'h5A; wb.we = 1'b1; wb.sel = 1'b1; wb.cyc = 1'b1; wb.stb = 1'b1;
    @(posedge clk_i); #1;
    wb.adr = 8'h07; wb.dat_w = 8'hFF; wb.we = 1'b0; wb.stb = 1'b0;
    lat = 1; a = 1'b0;
    while (!a && lat < 16) begin
      @(posedge clk_i); #1;
      lat++;
      a = wb.ack;
    end
    chk("wait_change_lat", 32'(lat), 32'(WS + 1));
    model[6] = 8'h5A;
    drive_idle();
    @(posedge clk_i); #1;
    do_model("wait_change_rd06", 8'h06, 8'h00, 1'b0, 1'b1);
    do_model("wait_change_rd07", 8'h07, 8'h00, 1'b0, 1'b1);

    // STB held high: a new request is sampled only once the slave is back in IDLE
    do_model("b2b_wr05", 8'h05, 8'hC3, 1'b1, 1'b1);
    @(negedge clk_i);
    wb.adr = 8'h05; wb.we = 1'b0; wb.sel = 1'b1; wb.cyc = 1'b1; wb.stb = 1'b1;
    nack = 0; prev = 0; seen = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk_i); #1;
      if (wb.ack) begin
        nack++;
        if (prev != 0) seen = 1'b1;
        if (wb.dat_r !== model[5]) seen = 1'b1;
      end
      prev = int'(wb.ack);
    end
    chk("b2b_ack_count", 32'(nack), 32'(9 / (WS + 2)));
    chk("b2b_ack_gap_data", 32'(seen), 32'd0);
    drive_idle();
    @(posedge clk_i); #1;

    // reset in the middle of a write, with the interrupt asserted
    do_model("rst_intr_set", 8'h0F, 8'h01, 1'b1, 1'b1);
    @(negedge clk_i);
    wb.adr = 8'h04; wb.dat_w = 8'h99; wb.we = 1'b1; wb.sel = 1'b1; wb.cyc = 1'b1; wb.stb = 1'b1;
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    chk("midrst_ack",  32'(wb.ack),   32'd0);
    chk("midrst_err",  32'(wb.err),   32'd0);
    chk("midrst_dat",  32'(wb.dat_r), 32'd0);
    chk("midrst_intr", 32'(wb.intr),  32'd0);
    drive_idle();
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    do_model("midrst_rd04", 8'h04, 8'h00, 1'b0, 1'b1);
    do_model("midrst_rd0f", 8'h0F, 8'h00, 1'b0, 1'b1);

    // randomized traffic against the array model
    for (int n = 0; n < 150; n++) begin
      logic [7:0] radr, rdat;
      logic rwe, rsel;
      radr = 8'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) radr = 8'h0F;
      rdat = 8'($urandom);
      rwe  = 1'($urandom);
      rsel = ($urandom_range(0, 3) != 0);
      do_model("rnd", radr, rdat, rwe, rsel);
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wbslave_regs.md
Name: wbslave_regs

Overview:
- Wishbone classic slave that sits directly downstream of wbmaster.
- Consumes the master's ADR/DAT/WE/SEL/STB/CYC cycles and returns ACK or ERR plus read data.
- Holds a small register file with a programmable number of wait states.
- Drives an interrupt line into the master's INTR_I.

Parameters:
- AW, `address_width, address bus width
- DW, `data_width, data bus width (8)
- SW, `select_width, select bus width (1)
- DEPTH, 16, number of DW-bit registers (power of 2, 2..2^AW)
- WAIT_STATES, 1, cycles inserted between request sample and ACK (0..15)

Ports:
- CLK_I  in  1  clock, all flops on rising edge
- RST_I  in  1  reset, asynchronous, active-low
- ADR_I  in  AW  byte address from master
- DAT_I  in  DW  write data from master
- WE_I  in  1  1 = write, 0 = read
- SEL_I  in  SW  lane select; write is performed only if SEL_I[0]=1
- STB_I  in  1  strobe
- CYC_I  in  1  bus cycle valid
- DAT_O  out  DW  read data
- ACK_O  out  1  normal termination
- ERR_O  out  1  error termination
- INTR_O  out  1  interrupt request to master

Behaviour:
- Reset (RST_I=0, async): state=IDLE, ACK_O=0, ERR_O=0, DAT_O=0, INTR_O=0, all registers=0, wait counter=0.
- FSM states: IDLE, WAIT, ACK, ERR.
- IDLE:
  - On a rising edge with CYC_I&STB_I=1, latch ADR_I, DAT_I, WE_I, SEL_I.
  - If the address is illegal, go to ERR.
  - Else if WAIT_STATES=0, go to ACK.
  - Else load counter=WAIT_STATES-1 and go to WAIT.
- WAIT:
  - If CYC_I=0 (abort), go to IDLE; no write occurs, no ACK.
  - Else if counter=0, go to ACK; otherwise decrement.
- ACK:
  - ACK_O=1 for exactly one cycle.
  - Read: DAT_O=reg[addr] during the same cycle.
  - Write: reg[addr]<=latched data on the edge leaving ACK, only if SEL[0]=1.
  - Next state is IDLE.
- ERR: ERR_O=1 for exactly one cycle, no register change, DAT_O=0, next state IDLE.
- ACK_O and ERR_O are registered, mutually exclusive, and never both 1.
- Latency: ACK_O/ERR_O rises WAIT_STATES+1 edges after the edge that sampled the request (ERR always after 1 edge).
- Minimum 2 cycles per transfer: back-to-back STB is sampled again in IDLE on the edge after ACK.
- DAT_O=0 whenever ACK_O=0; no tri-state.
- Register index = ADR_I[log2(DEPTH)-1:0].
- Interrupt:
  - INTR_O = reg[DEPTH-1][0], registered.
  - Set by writing bit0=1 to address DEPTH-1; cleared by writing bit0=0.
- Read of address DEPTH-1 returns the full stored byte.
- Request sampled with CYC_I=1, STB_I=0: ignored.
- STB_I or ADR_I changing during WAIT: ignored; latched values are used.
- Reset mid-transfer: immediate return to IDLE, outputs 0, pending write discarded.

Optional Feature:
- Macro: WBSLAVE_ADDR_CHECK_EN.
- Defined: ADR_I >= DEPTH is illegal and terminates with ERR_O.
- Undefined: all addresses are legal and alias modulo DEPTH; the ERR state is never entered and ERR_O is tied 0.

Decomposition:
- Shared package / `def.v additions:
  - FSM state encodings (2 bits): WB_S_IDLE=0, WB_S_WAIT=1, WB_S_ACK=2, WB_S_ERR=3.
  - Reuse `address_width, `data_width, `select_width.
- One natural sub-module, wbslave_regfile:
  - DEPTH x DW storage, synchronous write, combinational read.
  - Async active-low clear.
  - Exports bit0 of the last entry for INTR_O.

Test Plan (DEPTH=16, WAIT_STATES=1):
- Write 0x3C to 0x05 (CYC=STB=WE=SEL=1), then read 0x05 -> ACK_O high 2 edges after sample, one cycle each time; read DAT_O=0x3C during ACK; ERR_O stays 0.
- Write 0x01 to 0x0F -> INTR_O=1 the cycle after ACK; then write 0x00 to 0x0F -> INTR_O=0.
- Write 0x77 to 0x20 -> with WBSLAVE_ADDR_CHECK_EN: ERR_O for 1 cycle and reg[0] unchanged (0x00). Without the macro: ACK_O, and a read of 0x00 returns 0x77.
- Write 0xAA to 0x03 with SEL_I=0 -> ACK_O asserted; a following read of 0x03 returns 0x00.
- Start a write of 0x55 to 0x02, drop CYC_I in WAIT -> no ACK_O/ERR_O; a read of 0x02 returns 0x00.
- Pull RST_I low during WAIT of a write of 0x99 to 0x04 -> all outputs 0 immediately; after release, a read of 0x04 returns 0x00.
